// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, registered byte/strobe outputs.
// Handshake: o_rx_byte_recv_sig is valid-only (no ready); capture o_rx_byte_data in that cycle.
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_byte_data,
  output logic       o_rx_byte_recv_sig,
  output logic       o_rx_framing_error,
  output logic       o_rx_busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FLUSH = CW'(2);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic          rx_meta;
  logic          rx_s;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic [7:0]    data_n;
  logic          recv_n;
  logic          ferr_n;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state              <= WAIT_IDLE;
      cnt                <= '0;
      idx                <= '0;
      shift              <= '0;
      o_rx_byte_data     <= '0;
      o_rx_byte_recv_sig <= 1'b0;
      o_rx_framing_error <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      idx                <= idx_n;
      shift              <= shift_n;
      o_rx_byte_data     <= data_n;
      o_rx_byte_recv_sig <= recv_n;
      o_rx_framing_error <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = o_rx_byte_data;
    recv_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      // The synchroniser resets high, so a high line is trusted only once it
      // has been seen for longer than the synchroniser's flush time.
      WAIT_IDLE: begin
        if (!rx_s) begin
          cnt_n = '0;
        end else if (cnt == FLUSH) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            recv_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: state_n = WAIT_IDLE;
    endcase
  end

  always_comb begin
    o_rx_busy = (state == START) || (state == DATA) || (state == STOP);
    dbg_state = state;
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver at CLKS_PER_BIT=8: vector table, corner sequences, random frames.
module tb_uart_byte_receiver;
  localparam int C   = 8;
  localparam int LAT = 2 + (C - 1) / 2 + 1 + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       recv;
  logic       ferr;
  logic       busy;
  logic [2:0] dbg_state;

  uart_byte_receiver #(.CLKS_PER_BIT(C)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_uart_rx         (rx),
    .o_rx_byte_data    (data),
    .o_rx_byte_recv_sig(recv),
    .o_rx_framing_error(ferr),
    .o_rx_busy         (busy),
    .dbg_state         (dbg_state)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc++;

  // Scoreboard: expected events in frame order
  logic [7:0] exp_q[$];
  bit         err_q[$];
  int         fall_q[$];
  logic [7:0] rx_log[$];

  int checks = 0;
  int errors = 0;
  int n_recv = 0;
  int n_err  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge
  logic       prev_recv = 1'b0;
  logic       prev_err  = 1'b0;
  logic       prev_rst  = 1'b1;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    logic [7:0] eb;
    bit         ee;
    int         ef;
    int         d;
    if (recv || ferr) begin
      check("strobes_exclusive", 32'(recv & ferr), 32'd0);
      check("strobe_one_cycle", 32'((recv & prev_recv) | (ferr & prev_err)), 32'd0);
      if (recv) n_recv++;
      if (ferr) n_err++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe recv=%0b err=%0b data=%0h required=none", recv, ferr, data);
      end else begin
        eb = exp_q.pop_front();
        ee = err_q.pop_front();
        ef = fall_q.pop_front();
        check("strobe_kind_err", 32'(ferr), 32'(ee));
        if (!ee) begin
          check("byte_data", 32'(data), 32'(eb));
          rx_log.push_back(data);
        end
        d = pcyc - ef;
        check("latency", (d >= LAT - 1 && d <= LAT + 1) ? LAT : d, LAT);
      end
    end
    if (!prev_rst) check("data_hold", 32'((data !== prev_data) && !recv), 32'd0);
    prev_recv = recv;
    prev_err  = ferr;
    prev_rst  = rst;
    prev_data = data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input bit v);
    rx = v;
    tick(C);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit chk_busy);
    exp_q.push_back(b);
    err_q.push_back(!stop_ok);
    fall_q.push_back(pcyc);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (chk_busy && i == 3) check("busy_mid_frame", 32'(busy), 32'd1);
    end
    send_bit(stop_ok);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick(1);
      t++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
    err_q.delete();
    fall_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    int         exp_recv;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int r0, e0, l0;
    logic [31:0] word;
    logic [7:0] model_last;
    int exp_good, exp_bad;
    logic [7:0] b;
    bit ok;

    vecs[0] = '{8'hA5, 1'b1, 8,  1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 4,  1, 0, 8'hFF};
    vecs[3] = '{8'h80, 1'b1, 8,  1, 0, 8'h80};
    vecs[4] = '{8'h11, 1'b1, 8,  1, 0, 8'h11};
    vecs[5] = '{8'h3C, 1'b0, 16, 0, 1, 8'h11};

    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset_data", 32'(data), 32'h00);
    check("reset_recv", 32'(recv), 32'd0);
    check("reset_err", 32'(ferr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    tick(2 * C);

    for (int i = 0; i < 6; i++) begin
      r0 = n_recv;
      e0 = n_err;
      send_frame(vecs[i].data, vecs[i].stop_ok, i == 0);
      rx = 1'b1;
      tick(vecs[i].gap);
      drain();
      tick(2);
      check("vec_recv_count", n_recv - r0, vecs[i].exp_recv);
      check("vec_err_count", n_err - e0, vecs[i].exp_err);
      check("vec_data", 32'(data), 32'(vecs[i].exp_data));
      check("vec_busy_after", 32'(busy), 32'd0);
    end

    // Back-to-back frames into a 4-byte deserialiser
    r0 = n_recv;
    l0 = rx_log.size();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    rx = 1'b1;
    drain();
    check("b2b_recv_count", n_recv - r0, 32'd4);
    word = 32'h0;
    for (int i = 0; i < 4; i++)
      if (l0 + i < rx_log.size()) word = {word[23:0], rx_log[l0+i]};
    check("b2b_word", word, 32'h01020304);
    tick(C);

    // Two-cycle glitch
    r0 = n_recv;
    e0 = n_err;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(8);
    check("glitch_busy_cleared", 32'(busy), 32'd0);
    tick(10 * C);
    check("glitch_recv_count", n_recv - r0, 32'd0);
    check("glitch_err_count", n_err - e0, 32'd0);

    // Framing error followed by a long low line
    send_frame(8'h11, 1'b1, 1'b0);
    drain();
    r0 = n_recv;
    e0 = n_err;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(40);
    check("ferr_data_kept", 32'(data), 32'h11);
    check("ferr_count", n_err - e0, 32'd1);
    rx = 1'b1;
    tick(C);
    send_frame(8'h77, 1'b1, 1'b0);
    drain();
    check("after_ferr_data", 32'(data), 32'h77);
    check("after_ferr_recv", n_recv - r0, 32'd1);

    // Reset in the middle of the data bits of 0xFF
    tick(C);
    r0 = n_recv;
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_recv", 32'(recv), 32'd0);
    check("midreset_err", 32'(ferr), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    tick(12 * C);
    check("midreset_no_strobe", (n_recv - r0) + (n_err - e0), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    drain();
    check("midreset_5a_data", 32'(data), 32'h5A);
    check("midreset_5a_recv", n_recv - r0, 32'd1);

    // Reset released with the line low
    r0 = n_recv;
    e0 = n_err;
    rx  = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(30);
    rx = 1'b1;
    tick(C);
    send_frame(8'hC3, 1'b1, 1'b0);
    drain();
    check("lowreset_recv", n_recv - r0, 32'd1);
    check("lowreset_err", n_err - e0, 32'd0);
    check("lowreset_data", 32'(data), 32'hC3);

    // Random frames against the byte-level model
    tick(C);
    r0 = n_recv;
    e0 = n_err;
    exp_good = 0;
    exp_bad = 0;
    model_last = 8'hC3;
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, 1'b0);
      rx = 1'b1;
      if (ok) begin
        exp_good++;
        model_last = b;
        tick($urandom_range(0, 10));
      end else begin
        exp_bad++;
        tick($urandom_range(C, 2 * C));
      end
    end
    drain();
    check("rand_recv_count", n_recv - r0, exp_good);
    check("rand_err_count", n_err - e0, exp_bad);
    check("rand_last_data", 32'(data), 32'(model_last));

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
